// File: rtl/scan_encoder_pkg.sv
// scan_encoder_pkg: state encodings and index-width helper shared by the encoder family
package scan_encoder_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/scan_encoder_if.sv
// scan_encoder_if: request-vector input handshake and index-stream output handshake
interface scan_encoder_if import scan_encoder_pkg::*; #(
  parameter int N = 8,
  parameter int IDX_W = idx_w(N)
);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] in_vec;
  logic out_valid;
  logic out_ready;
  logic [IDX_W-1:0] out_idx;
  logic out_last;
  logic out_zero;
  modport master (
    output in_valid, in_vec, out_ready,
    input in_ready, out_valid, out_idx, out_last, out_zero
  );
  modport slave (
    input in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/scan_encoder_pri_enc.sv
// pri_enc: combinational priority encoder, highest or lowest set bit wins
module pri_enc import scan_encoder_pkg::*; #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W = idx_w(N)
) (
  input logic [N-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic any
);
  // later iterations overwrite earlier ones, so the scan direction picks the winner
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = 0; i < N; i++)
      if (vec[MSB_FIRST ? i : N-1-i]) idx = IDX_W'(MSB_FIRST ? i : N-1-i);
  end
endmodule

// File: rtl/scan_encoder.sv
// scan_encoder: streams the index of every set bit of an accepted vector, one per beat
module scan_encoder import scan_encoder_pkg::*; #(
  parameter int N = 8,
  parameter int IDX_W = idx_w(N),
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic flush,
  output logic busy,
  scan_encoder_if.slave bus
);
  state_t state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic zflag_q, zflag_d;
  logic [IDX_W-1:0] idx;
  logic any;
  logic last;
  logic scan;
  pri_enc #(.N(N), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_pri (
    .vec(pend_q),
    .idx(idx),
    .any(any)
  );
  assign scan = (state_q == ST_SCAN);
  assign last = ((pend_q & (pend_q - N'(1))) == '0);
  assign bus.in_ready = !scan;
  assign bus.out_valid = scan;
  assign bus.out_idx = (scan && any) ? idx : '0;
  assign bus.out_last = scan && last;
  assign bus.out_zero = zflag_q;
  assign busy = scan;
  // next state: flush aborts, idle accepts a vector, scan retires one bit per transfer
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    zflag_d = zflag_q;
    if (flush) begin
      state_d = ST_IDLE;
      pend_d = '0;
      zflag_d = 1'b0;
    end else if (!scan && bus.in_valid) begin
      state_d = ST_SCAN;
      pend_d = bus.in_vec;
      zflag_d = (bus.in_vec == '0);
    end else if (scan && bus.out_ready) begin
      pend_d = pend_q & ~(N'(1) << idx);
      state_d = last ? ST_IDLE : ST_SCAN;
      zflag_d = last ? 1'b0 : zflag_q;
    end
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q <= '0;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      zflag_q <= zflag_d;
    end
  end
endmodule

// File: tb/tb_scan_encoder.sv
// tb_scan_encoder: MSB-first and LSB-first encoders checked against a queue model
module tb_scan_encoder;
  localparam int N = 8;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [N-1:0] in_vec;
  logic busy_m, busy_l;
  int errors = 0;
  int checks = 0;
  int qm[$];
  int ql[$];
  bit act, zf;
  always #5 clk = ~clk;
  scan_encoder_if #(.N(N), .IDX_W(W)) im ();
  scan_encoder_if #(.N(N), .IDX_W(W)) il ();
  assign im.in_valid = in_valid;
  assign im.in_vec = in_vec;
  assign im.out_ready = out_ready;
  assign il.in_valid = in_valid;
  assign il.in_vec = in_vec;
  assign il.out_ready = out_ready;
  scan_encoder #(.N(N), .IDX_W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy_m), .bus(im)
  );
  scan_encoder #(.N(N), .IDX_W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy_l), .bus(il)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("valid_m", 32'(im.out_valid), 32'(act));
    chk("valid_l", 32'(il.out_valid), 32'(act));
    chk("ready_m", 32'(im.in_ready), 32'(!act));
    chk("ready_l", 32'(il.in_ready), 32'(!act));
    chk("busy_m", 32'(busy_m), 32'(act));
    chk("busy_l", 32'(busy_l), 32'(act));
    chk("idx_m", 32'(im.out_idx), act ? qm[0] : 0);
    chk("idx_l", 32'(il.out_idx), act ? ql[0] : 0);
    chk("last_m", 32'(im.out_last), 32'(act && qm.size() <= 1));
    chk("last_l", 32'(il.out_last), 32'(act && ql.size() <= 1));
    chk("zero_m", 32'(im.out_zero), 32'(zf));
    chk("zero_l", 32'(il.out_zero), 32'(zf));
    if (rst || flush) begin
      qm.delete(); ql.delete(); act = 0; zf = 0;
    end else if (!act && in_valid) begin
      act = 1;
      zf = (in_vec == 0);
      for (int i = N-1; i >= 0; i--) if (in_vec[i]) qm.push_back(i);
      for (int i = 0; i < N; i++) if (in_vec[i]) ql.push_back(i);
      if (zf) begin qm.push_back(0); ql.push_back(0); end
    end else if (act && out_ready) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
      if (qm.size() == 0) begin act = 0; zf = 0; end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [N-1:0] v);
    in_valid = 1; in_vec = v;
    cyc();
    in_valid = 0; in_vec = '0;
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; in_vec = '0; out_ready = 1;
    act = 0; zf = 0;
    @(posedge clk);
    #1;
    cyc();
    rst = 0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      send(8'h80 >> k);
      cyc();
      cyc();
    end
    send(8'hA5);
    repeat (5) cyc();
    out_ready = 0;
    send(8'h60);
    repeat (3) cyc();
    out_ready = 1;
    repeat (3) cyc();
    send(8'h00);
    repeat (2) cyc();
    send(8'hFF);
    repeat (2) cyc();
    flush = 1;
    cyc();
    flush = 0;
    repeat (2) cyc();
    send(8'hFF);
    repeat (2) cyc();
    rst = 1;
    cyc();
    rst = 0;
    repeat (2) cyc();
    send(8'h81);
    in_valid = 1; in_vec = 8'h01;
    cyc();
    in_valid = 0; in_vec = '0;
    repeat (2) cyc();
    flush = 1; in_valid = 1; in_vec = 8'h3C;
    cyc();
    flush = 0; in_valid = 0; in_vec = '0;
    cyc();
    for (int t = 0; t < 400; t++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_vec = N'($urandom);
      if ($urandom_range(0, 7) == 0) in_vec = '0;
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 59) == 0);
      cyc();
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    repeat (10) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
